// File: rtl/mem_addr_gen.sv
// mem_addr_gen: bounded address sequencer for the memory display path.
// Walks [lo..hi] with a programmable step in wrap-up, wrap-down or one-shot mode
// and flags wrap/done events alongside the address.
// Optional build macro: MEM_ADDR_GEN_PINGPONG_EN (mode 11 = ping-pong; otherwise
// mode 11 is an alias of mode 00).
module mem_addr_gen #(
  parameter int AW     = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  input  logic              stop,
  input  logic [AW-1:0]     lo,
  input  logic [AW-1:0]     hi,
  input  logic [STEP_W-1:0] step,
  input  logic [1:0]        mode,
  output logic [AW-1:0]     addr,
  output logic              valid,
  output logic              wrap,
  output logic              done,
  output logic              cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DN   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    M_WRAP_UP  = 2'b00,
    M_WRAP_DN  = 2'b01,
    M_ONESHOT  = 2'b10,
    M_PINGPONG = 2'b11
  } mode_t;

  state_t              state, state_d;
  logic [AW-1:0]       addr_d;
  logic                wrap_d;
  logic                cfg_err_d;
  logic [AW-1:0]       lo_q, lo_d;
  logic [AW-1:0]       hi_q, hi_d;
  logic [STEP_W-1:0]   step_q, step_d;
  mode_t               mode_q, mode_d;

  // Bound checks use one extra bit so addr+step never silently wraps past 2^AW.
  logic [AW:0]         up_sum;
  logic [AW:0]         dn_floor;
  logic                up_over;
  logic                dn_under;
  logic [AW-1:0]       dn_next;

  // Step arithmetic against the latched configuration.
  always_comb begin
    up_sum   = {1'b0, addr} + (AW+1)'(step_q);
    dn_floor = {1'b0, lo_q} + (AW+1)'(step_q);
    up_over  = up_sum > {1'b0, hi_q};
    dn_under = {1'b0, addr} < dn_floor;
    dn_next  = addr - AW'(step_q);
  end

  // Next-state and next-output logic; start has priority over stop and en.
  always_comb begin
    state_d   = state;
    addr_d    = addr;
    wrap_d    = 1'b0;
    cfg_err_d = cfg_err;
    lo_d      = lo_q;
    hi_d      = hi_q;
    step_d    = step_q;
    mode_d    = mode_q;

    if (start) begin
      if (lo > hi) begin
        state_d   = S_IDLE;
        cfg_err_d = 1'b1;
      end else begin
        cfg_err_d = 1'b0;
        lo_d      = lo;
        hi_d      = hi;
        step_d    = (step == '0) ? STEP_W'(1) : step;
        mode_d    = mode_t'(mode);
        if (mode_t'(mode) == M_WRAP_DN) begin
          state_d = S_DN;
          addr_d  = hi;
        end else begin
          state_d = S_UP;
          addr_d  = lo;
        end
      end
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (en) begin
      case (state)
        S_UP: begin
          if (up_over) begin
            wrap_d = 1'b1;
            if (mode_q == M_ONESHOT) begin
              state_d = S_DONE;
`ifdef MEM_ADDR_GEN_PINGPONG_EN
            end else if (mode_q == M_PINGPONG) begin
              // Reverse: max(addr-step, lo); dn_under means addr-step < lo.
              state_d = S_DN;
              addr_d  = dn_under ? lo_q : dn_next;
`endif
            end else begin
              addr_d = lo_q;
            end
          end else begin
            addr_d = up_sum[AW-1:0];
          end
        end
        S_DN: begin
          if (dn_under) begin
            wrap_d = 1'b1;
`ifdef MEM_ADDR_GEN_PINGPONG_EN
            if (mode_q == M_PINGPONG) begin
              // Reverse: min(addr+step, hi).
              state_d = S_UP;
              addr_d  = up_over ? hi_q : up_sum[AW-1:0];
            end else begin
              addr_d = hi_q;
            end
`else
            addr_d = hi_q;
`endif
          end else begin
            addr_d = dn_next;
          end
        end
        default: ;
      endcase
    end
  end

  // State, address, event and configuration registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      addr    <= '0;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      mode_q  <= M_WRAP_UP;
    end else begin
      state   <= state_d;
      addr    <= addr_d;
      wrap    <= wrap_d;
      cfg_err <= cfg_err_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      mode_q  <= mode_d;
    end
  end

  assign valid = (state == S_UP) || (state == S_DN);
  assign done  = (state == S_DONE);

endmodule
